// File: rtl/pulse_capture_pkg.sv
// Shared types and default parameters for the pulse capture sequencer.
package pulse_capture_pkg;

   localparam int DEF_BUS_WIDTH  = 32;
   localparam int DEF_FIFO_DEPTH = 8;
   localparam int DEF_TIMEOUT    = 1048576;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARM,
      ST_WAIT,
      ST_READ,
      ST_CLEAR
   } state_t;

endpackage

// File: rtl/capture_result_fifo.sv
// First-word-fall-through result FIFO with level and simultaneous push/pop.
module capture_result_fifo #(
   parameter int WIDTH = 32,
   parameter int DEPTH = 8
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     push_i,
   input  logic [WIDTH-1:0]         data_i,
   input  logic                     pop_i,
   output logic [WIDTH-1:0]         data_o,
   output logic                     empty_o,
   output logic                     full_o,
   output logic [$clog2(DEPTH):0]   level_o,
   output logic                     drop_o
);

   localparam int AW = $clog2(DEPTH);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
   logic [AW:0]      level_q, level_d;
   logic             pop_ok, push_ok;

   assign empty_o = (level_q == '0);
   assign full_o  = (level_q == (AW+1)'(DEPTH));
   assign pop_ok  = pop_i && !empty_o;
   // A full FIFO still takes a push when the head leaves on the same edge.
   assign push_ok = push_i && (!full_o || pop_ok);
   assign drop_o  = push_i && !push_ok;
   assign level_o = level_q;
   assign data_o  = empty_o ? '0 : mem_q[rd_ptr_q];

   always_comb begin
      level_d = level_q;
      case ({push_ok, pop_ok})
         2'b10:   level_d = level_q + 1'b1;
         2'b01:   level_d = level_q - 1'b1;
         default: level_d = level_q;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem_q[wr_ptr_q] <= data_i;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         level_q  <= '0;
      end else begin
         if (push_ok) wr_ptr_q <= wr_ptr_q + 1'b1;
         if (pop_ok)  rd_ptr_q <= rd_ptr_q + 1'b1;
         level_q <= level_d;
      end
   end

endmodule

// File: rtl/pulse_capture_sequencer.sv
// Drives an external capture unit (trigger/wait/read/clear) and queues results.
// Optional min/max pulse statistics when PULSE_CAPTURE_STATS_EN is defined.
module pulse_capture_sequencer
   import pulse_capture_pkg::*;
#(
   parameter int BUS_WIDTH  = DEF_BUS_WIDTH,
   parameter int FIFO_DEPTH = DEF_FIFO_DEPTH,
   parameter int TIMEOUT    = DEF_TIMEOUT
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          start,
   input  logic                          stop,
   input  logic [7:0]                    count,
   output logic                          cap_trigger,
   output logic                          cap_oe,
   output logic                          cap_int_clr,
   input  logic                          cap_int,
   input  logic [BUS_WIDTH-1:0]          cap_data,
   input  logic                          rd_en,
   output logic [BUS_WIDTH-1:0]          rd_data,
`ifdef PULSE_CAPTURE_STATS_EN
   output logic [BUS_WIDTH-1:0]          min_width,
   output logic [BUS_WIDTH-1:0]          max_width,
`endif
   output logic                          empty,
   output logic                          full,
   output logic                          busy,
   output logic                          overflow,
   output logic                          timeout,
   output logic [$clog2(FIFO_DEPTH):0]   level
);

   localparam int            TW        = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] WAIT_LAST = TW'(TIMEOUT - 1);

   state_t        state_q, state_d;
   logic [7:0]    remaining_q, remaining_d;
   logic [TW-1:0] wait_q, wait_d;
   logic          stop_pend_q, stop_pend_d;
   logic          timeout_q, timeout_d;
   logic          overflow_q, overflow_d;
   logic          trig_q, oe_q, clr_q;
   logic          start_run, push, fifo_drop;

   assign start_run = (state_q == ST_IDLE) && start && !stop;
   assign push      = (state_q == ST_READ);

   always_comb begin
      state_d     = state_q;
      remaining_d = remaining_q;
      wait_d      = wait_q;
      stop_pend_d = stop_pend_q;
      timeout_d   = timeout_q;
      overflow_d  = overflow_q | fifo_drop;
      case (state_q)
         ST_IDLE: begin
            if (start_run) begin
               state_d     = ST_ARM;
               remaining_d = count;
               stop_pend_d = 1'b0;
               timeout_d   = 1'b0;
               overflow_d  = 1'b0;
            end
         end
         ST_ARM: begin
            wait_d  = '0;
            state_d = stop ? ST_IDLE : ST_WAIT;
         end
         ST_WAIT: begin
            if (stop) begin
               state_d = ST_IDLE;
            end else if (cap_int) begin
               state_d = ST_READ;
            end else if (wait_q == WAIT_LAST) begin
               state_d   = ST_IDLE;
               timeout_d = 1'b1;
            end else begin
               wait_d = wait_q + 1'b1;
            end
         end
         ST_READ: begin
            // A stop here is deferred so the unit is always left cleared.
            state_d = ST_CLEAR;
            if (stop) stop_pend_d = 1'b1;
         end
         ST_CLEAR: begin
            if (remaining_q != 8'd0) remaining_d = remaining_q - 8'd1;
            if (stop || stop_pend_q || remaining_q == 8'd1) state_d = ST_IDLE;
            else                                              state_d = ST_ARM;
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         remaining_q <= '0;
         wait_q      <= '0;
         stop_pend_q <= 1'b0;
         timeout_q   <= 1'b0;
         overflow_q  <= 1'b0;
         trig_q      <= 1'b0;
         oe_q        <= 1'b0;
         clr_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         remaining_q <= remaining_d;
         wait_q      <= wait_d;
         stop_pend_q <= stop_pend_d;
         timeout_q   <= timeout_d;
         overflow_q  <= overflow_d;
         // Strobes decoded from next state so each is a clean flop output.
         trig_q      <= (state_d == ST_ARM);
         oe_q        <= (state_d == ST_READ);
         clr_q       <= (state_d == ST_CLEAR);
      end
   end

   assign cap_trigger = trig_q;
   assign cap_oe      = oe_q;
   assign cap_int_clr = clr_q;
   assign busy        = (state_q != ST_IDLE);
   assign timeout     = timeout_q;
   assign overflow    = overflow_q;

   capture_result_fifo #(
      .WIDTH (BUS_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst_n),
      .push_i  (push),
      .data_i  (cap_data),
      .pop_i   (rd_en),
      .data_o  (rd_data),
      .empty_o (empty),
      .full_o  (full),
      .level_o (level),
      .drop_o  (fifo_drop)
   );

`ifdef PULSE_CAPTURE_STATS_EN
   logic [BUS_WIDTH-1:0] min_q, max_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         min_q <= '1;
         max_q <= '0;
      end else if (start_run) begin
         min_q <= '1;
         max_q <= '0;
      end else if (push) begin
         if (cap_data < min_q) min_q <= cap_data;
         if (cap_data > max_q) max_q <= cap_data;
      end
   end

   assign min_width = min_q;
   assign max_width = max_q;
`endif

endmodule

// File: tb/tb_pulse_capture_sequencer.sv
// Directed bench for pulse_capture_sequencer with a behavioural capture unit.
module tb_pulse_capture_sequencer;

   localparam int BW    = 32;
   localparam int DEPTH = 8;
   localparam int TMO   = 100;

   logic          clk, rst_n, start, stop, rd_en;
   logic [7:0]    count;
   logic          cap_trigger, cap_oe, cap_int_clr, cap_int;
   logic [BW-1:0] cap_data, rd_data;
   logic          empty, full, busy, overflow, timeout;
   logic [3:0]    level;
`ifdef PULSE_CAPTURE_STATS_EN
   logic [BW-1:0] min_width, max_width;
`endif

   logic          unit_en, unit_rst;
   logic [BW-1:0] vals [16];
   int            cd, vidx;
   int            trig_cnt, oe_cnt, clr_cnt;
   int            n_chk, n_err;

   pulse_capture_sequencer #(
      .BUS_WIDTH  (BW),
      .FIFO_DEPTH (DEPTH),
      .TIMEOUT    (TMO)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .start       (start),
      .stop        (stop),
      .count       (count),
      .cap_trigger (cap_trigger),
      .cap_oe      (cap_oe),
      .cap_int_clr (cap_int_clr),
      .cap_int     (cap_int),
      .cap_data    (cap_data),
      .rd_en       (rd_en),
      .rd_data     (rd_data),
`ifdef PULSE_CAPTURE_STATS_EN
      .min_width   (min_width),
      .max_width   (max_width),
`endif
      .empty       (empty),
      .full        (full),
      .busy        (busy),
      .overflow    (overflow),
      .timeout     (timeout),
      .level       (level)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Capture unit: raises cap_int three edges after a trigger, drops it on int_clr.
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cap_int  <= 1'b0;
         cap_data <= '0;
         cd       <= 0;
         vidx     <= 0;
      end else if (unit_rst) begin
         cap_int <= 1'b0;
         cd      <= 0;
         vidx    <= 0;
      end else begin
         if (cap_int_clr) cap_int <= 1'b0;
         if (cap_trigger && unit_en) begin
            cd <= 2;
         end else if (cd == 1) begin
            cap_int  <= 1'b1;
            cap_data <= vals[vidx % 16];
            vidx     <= vidx + 1;
            cd       <= 0;
         end else if (cd > 1) begin
            cd <= cd - 1;
         end
      end
   end

   initial begin
      trig_cnt = 0; oe_cnt = 0; clr_cnt = 0;
      forever begin
         @(posedge clk);
         trig_cnt += int'(cap_trigger);
         oe_cnt   += int'(cap_oe);
         clr_cnt  += int'(cap_int_clr);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s got %0d want %0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic go(input logic [7:0] c);
      count = c;
      start = 1'b1;
      tick(1);
      start = 1'b0;
   endtask

   task automatic unit_reset();
      unit_rst = 1'b1;
      tick(1);
      unit_rst = 1'b0;
   endtask

   task automatic wait_idle(input string tag, input int max);
      int i = 0;
      while (busy && i < max) begin
         tick(1);
         i++;
      end
      chk(tag, 32'(!busy), 1);
   endtask

   task automatic wait_oe(input string tag, input int max);
      int i = 0;
      while (!cap_oe && i < max) begin
         tick(1);
         i++;
      end
      chk(tag, 32'(cap_oe), 1);
   endtask

   task automatic pop_chk(input string tag, input logic [31:0] exp);
      chk(tag, rd_data, exp);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
   endtask

   initial begin
      int t0, o0, c0, n;
      n_chk = 0; n_err = 0;
      rst_n = 1'b0; start = 1'b0; stop = 1'b0; count = '0; rd_en = 1'b0;
      unit_en = 1'b1; unit_rst = 1'b0;
      for (int i = 0; i < 16; i++) vals[i] = '0;
      tick(2);

      chk("rst_busy",   32'(busy), 0);
      chk("rst_empty",  32'(empty), 1);
      chk("rst_level",  32'(level), 0);
      chk("rst_rdata",  rd_data, 0);
      chk("rst_strobe", 32'({cap_trigger, cap_oe, cap_int_clr}), 0);
      chk("rst_flags",  32'({full, overflow, timeout}), 0);
      rst_n = 1'b1;
      tick(1);

      // Three captures, latency and ordering
      vals[0] = 10; vals[1] = 20; vals[2] = 30;
      unit_reset();
      t0 = trig_cnt; c0 = clr_cnt;
      go(3);
      n = 0;
      while (!cap_int && n < 20) begin tick(1); n++; end
      chk("lat_int", 32'(cap_int), 1);
      tick(1);
      chk("lat_oe",     32'(cap_oe), 1);
      chk("lat_empty0", 32'(empty), 1);
      tick(1);
      chk("lat_clr",    32'({cap_oe, cap_int_clr}), 1);
      chk("lat_empty1", 32'(empty), 0);
      wait_idle("run3_idle", 200);
      chk("run3_trig",  32'(trig_cnt - t0), 3);
      chk("run3_clr",   32'(clr_cnt - c0), 3);
      chk("run3_level", 32'(level), 3);
      pop_chk("run3_d0", 10);
      pop_chk("run3_d1", 20);
      pop_chk("run3_d2", 30);
      chk("run3_empty", 32'(empty), 1);

      // Continuous mode, nine captures into an 8-deep FIFO
      for (int i = 0; i < 9; i++) vals[i] = BW'(i + 1);
      unit_reset();
      o0 = oe_cnt;
      go(0);
      n = 0;
      while (!(cap_oe && (oe_cnt - o0) == 8) && n < 400) begin tick(1); n++; end
      chk("ovf_ninth", 32'(cap_oe), 1);
      stop = 1'b1;
      tick(2);
      stop = 1'b0;
      wait_idle("ovf_idle", 10);
      chk("ovf_oe",    32'(oe_cnt - o0), 9);
      chk("ovf_level", 32'(level), 8);
      chk("ovf_full",  32'(full), 1);
      chk("ovf_flag",  32'(overflow), 1);
      chk("ovf_head",  rd_data, 1);

      // Full FIFO with a pop on the push edge
      vals[0] = 100;
      unit_reset();
      go(1);
      chk("pp_ovclr", 32'(overflow), 0);
      wait_oe("pp_oe", 50);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      wait_idle("pp_idle", 20);
      chk("pp_level", 32'(level), 8);
      chk("pp_ovf",   32'(overflow), 0);
      for (int i = 2; i <= 8; i++) pop_chk($sformatf("pp_d%0d", i), i);
      pop_chk("pp_new", 100);
      chk("pp_empty", 32'(empty), 1);
      rd_en = 1'b1;
      tick(1);
      rd_en = 1'b0;
      chk("pop_empty_lvl", 32'({empty, level}), 5'b10000);

      // Timeout with a silent unit
      unit_en = 1'b0;
      go(1);
      n = 0;
      tick(1);
      while (busy && n < 500) begin n++; tick(1); end
      chk("tmo_cycles", 32'(n), TMO);
      chk("tmo_flag",   32'(timeout), 1);
      unit_en = 1'b1;
      vals[0] = 55;
      unit_reset();
      go(1);
      chk("tmo_clear", 32'(timeout), 0);
      wait_idle("tmo_idle", 50);
      chk("tmo_data", rd_data, 55);
      chk("tmo_level", 32'(level), 1);

      // Stop in WAIT, start+stop together, start ignored while busy
      unit_en = 1'b0;
      o0 = oe_cnt; c0 = clr_cnt; t0 = trig_cnt;
      go(0);
      tick(1);
      start = 1'b1;
      tick(1);
      start = 1'b0;
      stop = 1'b1;
      tick(1);
      stop = 1'b0;
      chk("stop_busy", 32'(busy), 0);
      tick(5);
      chk("stop_oeclr", 32'((oe_cnt - o0) + (clr_cnt - c0)), 0);
      chk("stop_trig",  32'(trig_cnt - t0), 1);
      start = 1'b1; stop = 1'b1;
      tick(1);
      start = 1'b0; stop = 1'b0;
      chk("ss_idle", 32'(busy), 0);

      // Asynchronous reset in the middle of READ
      unit_en = 1'b1;
      vals[0] = 77;
      unit_reset();
      go(1);
      wait_oe("ar_oe", 50);
      #1 rst_n = 1'b0;
      #1;
      chk("ar_strobe", 32'({cap_trigger, cap_oe, cap_int_clr}), 0);
      chk("ar_busy",   32'(busy), 0);
      chk("ar_fifo",   32'({empty, level}), 5'b10000);
      chk("ar_rdata",  rd_data, 0);
      tick(2);
      rst_n = 1'b1;
      tick(1);

`ifdef PULSE_CAPTURE_STATS_EN
      chk("st_rmin", min_width, 32'hFFFF_FFFF);
      chk("st_rmax", max_width, 0);
      vals[0] = 7; vals[1] = 3; vals[2] = 9;
      unit_reset();
      go(3);
      wait_idle("st_idle", 200);
      chk("st_min", min_width, 3);
      chk("st_max", max_width, 9);
`endif

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/pulse_capture_sequencer.md
PULSE_CAPTURE_SEQUENCER -- requirements
Module: pulse_capture_sequencer

Interface
REQ-001 SHALL have parameter BUS_WIDTH, default 32, width of capture data and FIFO words.
REQ-002 SHALL have parameter FIFO_DEPTH, default 8, result FIFO entries, power of two, at least 2.
REQ-003 SHALL have parameter TIMEOUT, default 1048576, maximum cycles spent waiting for a capture event.
REQ-004 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-005 SHALL have port rst_n  in  1  asynchronous active-low reset.
REQ-006 SHALL have port start  in  1  begin a capture run (IDLE only).
REQ-007 SHALL have port stop  in  1  abort run.
REQ-008 SHALL have port count  in  8  captures per run; 0 = continuous until stop.
REQ-009 SHALL have port cap_trigger / cap_oe / cap_int_clr  out  1 each  drive the capture unit's trigger, oe, int_clr.
REQ-010 SHALL have port cap_int  in  1  capture unit interrupt flag.
REQ-011 SHALL have port cap_data  in  BUS_WIDTH  capture unit data, valid while cap_oe high.
REQ-012 SHALL have port rd_en  in  1  pop FIFO head.
REQ-013 SHALL have port rd_data  out  BUS_WIDTH  FIFO head (first-word fall-through).
REQ-014 SHALL have ports empty, full, busy, overflow, timeout  out  1 each; level  out  $clog2(FIFO_DEPTH)+1.

Function
REQ-015 SHALL implement states IDLE, ARM, WAIT, READ, CLEAR.
REQ-016 IDLE: start=1 -> ARM; clear overflow, timeout; load remaining=count.
REQ-017 ARM: cap_trigger=1 for exactly one cycle -> WAIT; reset wait counter.
REQ-018 WAIT: cap_int=1 -> READ; wait counter reaching TIMEOUT -> IDLE with timeout=1 (sticky).
REQ-019 READ: cap_oe=1 for one cycle; cap_data pushed into FIFO on that cycle's closing edge -> CLEAR.
REQ-020 CLEAR: cap_int_clr=1 for one cycle; if count!=0, decrement remaining; remaining reaching 0 -> IDLE, else -> ARM.
REQ-021 cap_trigger, cap_oe, cap_int_clr SHALL be registered, mutually exclusive, never high in IDLE.
REQ-022 Latency: cap_int sampled high at edge k -> cap_oe high in cycle k..k+1 -> empty low after edge k+1.
REQ-023 stop in ARM or WAIT -> IDLE next edge; stop in READ/CLEAR -> sequence completes through CLEAR, then IDLE.
REQ-024 start when busy SHALL be ignored; start and stop together in IDLE -> stay IDLE.
REQ-025 busy SHALL be 1 in every state except IDLE.
REQ-026 Push when full without simultaneous pop: sample dropped, overflow=1 (sticky until next start).
REQ-027 Push and pop same cycle when full: both accepted, no overflow; when empty: pop ignored, push accepted.
REQ-028 rd_en while empty SHALL be ignored; level, pointers unchanged.
REQ-029 FIFO pointers SHALL wrap modulo FIFO_DEPTH; level = entries held, 0..FIFO_DEPTH.

Reset
REQ-030 rst_n low SHALL force IDLE, all strobes 0, FIFO empty, level 0, rd_data 0, busy/overflow/timeout 0, immediately without clock.
REQ-031 Reset mid-run SHALL abandon the run; capture unit left as-is.

Configuration
REQ-032 PULSE_CAPTURE_STATS_EN defined: add outputs min_width, max_width (BUS_WIDTH) updated on each push; start loads min=all-ones, max=0; reset same.
REQ-033 PULSE_CAPTURE_STATS_EN undefined: ports and logic absent; all other behaviour identical.

Structure
REQ-034 State encoding enum and default parameter constants SHALL live in shared package pulse_capture_pkg.
REQ-035 FIFO SHALL be sub-module capture_result_fifo (FWFT, full/empty/level, simultaneous push/pop).

Verification
REQ-036 count=3, unit returns 10,20,30 -> FIFO holds 10,20,30 in order, busy falls after third CLEAR, three cap_trigger pulses.
REQ-037 count=0, 9 captures, no reads, FIFO_DEPTH=8 -> level 8, full=1, overflow=1, ninth value dropped.
REQ-038 full FIFO, rd_en held during push -> level stays 8, overflow=0, oldest value popped.
REQ-039 TIMEOUT=100, cap_int never asserts -> IDLE after 100 WAIT cycles, timeout=1; next start clears it.
REQ-040 stop in WAIT -> IDLE next edge, no cap_oe/cap_int_clr; rst_n low mid-READ -> all outputs 0 asynchronously.
REQ-041 PULSE_CAPTURE_STATS_EN, samples 7,3,9 -> min_width=3, max_width=9.
